// File: rtl/scan_pkg.sv
// Shared constants, row/frame types and capture FSM states for the
// LED row-scan frame capture block.
package scan_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef logic [COLS-1:0] row_t;
  typedef row_t [ROWS-1:0] frame_t;

  typedef enum logic [0:0] {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } cap_state_t;

endpackage

// File: rtl/scan_row_norm.sv
// Combinational polarity normalisation of one scanned RGB row:
// output bit 1 always means the pixel is lit.
module scan_row_norm #(
  parameter int unsigned WIDTH      = scan_pkg::COLS,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic [WIDTH-1:0] data_r,
  input  logic [WIDTH-1:0] data_g,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] lit_r,
  output logic [WIDTH-1:0] lit_g,
  output logic [WIDTH-1:0] lit_b
);

  always_comb begin
    lit_r = ACTIVE_LOW ? ~data_r : data_r;
    lit_g = ACTIVE_LOW ? ~data_g : data_g;
    lit_b = ACTIVE_LOW ? ~data_b : data_b;
  end

endmodule

// File: rtl/scan_frame_capture.sv
// Samples the row-scan bus, reassembles complete frames in a shadow buffer,
// publishes each validated frame and flags row-order errors and a stalled scan.
module scan_frame_capture #(
  parameter int unsigned ROWS        = scan_pkg::ROWS,
  parameter int unsigned COLS        = scan_pkg::COLS,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       restart,
  input  logic                       scan_strobe,
  input  logic                       En,
  input  logic [$clog2(ROWS)-1:0]    S,
  input  logic [COLS-1:0]            DATA_R,
  input  logic [COLS-1:0]            DATA_G,
  input  logic [COLS-1:0]            DATA_B,
  output logic [ROWS-1:0][COLS-1:0]  frame_r,
  output logic [ROWS-1:0][COLS-1:0]  frame_g,
  output logic [ROWS-1:0][COLS-1:0]  frame_b,
  output logic                       frame_valid,
  output logic                       frame_changed,
  output logic                       sync_err,
  output logic                       stale,
  output logic [15:0]                frame_count
);

  import scan_pkg::*;

  localparam int unsigned     SW       = $clog2(ROWS);
  localparam int unsigned     TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0]   LAST_ROW = SW'(ROWS - 1);
  localparam logic [TW-1:0]   TO_LIMIT = TW'(TIMEOUT_CYC);

  cap_state_t                 state_q, state_d;
  logic [SW-1:0]              exp_row_q, exp_row_d;
  logic [TW-1:0]              to_cnt_q;
  logic [ROWS-1:0][COLS-1:0]  shadow_r_q, shadow_g_q, shadow_b_q;
  logic [ROWS-1:0][COLS-1:0]  shadow_r_n, shadow_g_n, shadow_b_n;
  logic [COLS-1:0]            lit_r, lit_g, lit_b;
  logic                       sample_ev;
  logic                       store;
  logic                       commit;
  logic                       err;
  logic                       timeout_hit;

  scan_row_norm #(
    .WIDTH      (COLS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_norm (
    .data_r (DATA_R),
    .data_g (DATA_G),
    .data_b (DATA_B),
    .lit_r  (lit_r),
    .lit_g  (lit_g),
    .lit_b  (lit_b)
  );

  assign sample_ev = scan_strobe && En;

  always_comb begin
    state_d     = state_q;
    exp_row_d   = exp_row_q;
    store       = 1'b0;
    commit      = 1'b0;
    err         = 1'b0;
    timeout_hit = !sample_ev && (to_cnt_q == TO_LIMIT);
    if (sample_ev) begin
      case (state_q)
        HUNT: begin
          if (S == '0) begin
            store     = 1'b1;
            exp_row_d = SW'(1);
            state_d   = ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (S == exp_row_q) begin
            store = 1'b1;
            if (exp_row_q == LAST_ROW) begin
              commit    = 1'b1;
              exp_row_d = '0;
            end else begin
              exp_row_d = exp_row_q + 1'b1;
            end
          end else begin
            err = 1'b1;
            // A stray row 0 is taken as the start of a fresh frame.
            if (S == '0) begin
              store     = 1'b1;
              exp_row_d = SW'(1);
            end else begin
              state_d   = HUNT;
              exp_row_d = '0;
            end
          end
        end
        default: begin
          state_d   = HUNT;
          exp_row_d = '0;
        end
      endcase
    end else if (timeout_hit) begin
      state_d   = HUNT;
      exp_row_d = '0;
    end
  end

  // Final row is merged here so the commit copies a complete frame this edge.
  always_comb begin
    shadow_r_n = shadow_r_q;
    shadow_g_n = shadow_g_q;
    shadow_b_n = shadow_b_q;
    if (store) begin
      shadow_r_n[S] = lit_r;
      shadow_g_n[S] = lit_g;
      shadow_b_n[S] = lit_b;
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state_q   <= HUNT;
      exp_row_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_row_q <= exp_row_d;
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      to_cnt_q <= '0;
    end else if (sample_ev) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != TO_LIMIT) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      shadow_r_q    <= '0;
      shadow_g_q    <= '0;
      shadow_b_q    <= '0;
      frame_r       <= '0;
      frame_g       <= '0;
      frame_b       <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      sync_err      <= 1'b0;
      stale         <= 1'b1;
      frame_count   <= '0;
    end else begin
      shadow_r_q    <= shadow_r_n;
      shadow_g_q    <= shadow_g_n;
      shadow_b_q    <= shadow_b_n;
      frame_valid   <= commit;
      frame_changed <= commit &&
                       ({shadow_r_n, shadow_g_n, shadow_b_n} != {frame_r, frame_g, frame_b});
      sync_err      <= err;
      if (commit) begin
        frame_r     <= shadow_r_n;
        frame_g     <= shadow_g_n;
        frame_b     <= shadow_b_n;
        frame_count <= frame_count + 16'd1;
        stale       <= 1'b0;
      end else if (timeout_hit) begin
        stale       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_frame_capture.sv
// Self-checking bench for scan_frame_capture: directed scenarios plus
// randomized scan traffic compared against a queue-based frame model.
module tb_scan_frame_capture;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int T    = 100;

  logic                      clk = 1'b0;
  logic                      restart;
  logic                      scan_strobe;
  logic                      En;
  logic [2:0]                S;
  logic [7:0]                DATA_R, DATA_G, DATA_B;
  logic [ROWS-1:0][COLS-1:0] frame_r, frame_g, frame_b;
  logic                      frame_valid, frame_changed, sync_err, stale;
  logic [15:0]               frame_count;

  always #5 clk = ~clk;

  scan_frame_capture #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .ACTIVE_LOW  (1'b1),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk           (clk),
    .restart       (restart),
    .scan_strobe   (scan_strobe),
    .En            (En),
    .S             (S),
    .DATA_R        (DATA_R),
    .DATA_G        (DATA_G),
    .DATA_B        (DATA_B),
    .frame_r       (frame_r),
    .frame_g       (frame_g),
    .frame_b       (frame_b),
    .frame_valid   (frame_valid),
    .frame_changed (frame_changed),
    .sync_err      (sync_err),
    .stale         (stale),
    .frame_count   (frame_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the partial frame is simply the list of rows collected so
  // far; a row is accepted when its index equals the number already collected.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rowd_t;

  rowd_t       partial[$];
  bit          hunting;
  int          idle;
  logic [63:0] m_r, m_g, m_b;
  bit          m_fv, m_fc, m_se, m_stale;
  int          m_count;

  function automatic void model_reset();
    partial.delete();
    hunting = 1'b1;
    idle    = 0;
    m_r = '0; m_g = '0; m_b = '0;
    m_fv = 1'b0; m_fc = 1'b0; m_se = 1'b0;
    m_stale = 1'b1;
    m_count = 0;
  endfunction

  function automatic void model_commit();
    logic [63:0] nr, ng, nb;
    for (int i = 0; i < ROWS; i++) begin
      nr[i*8 +: 8] = partial[i].r;
      ng[i*8 +: 8] = partial[i].g;
      nb[i*8 +: 8] = partial[i].b;
    end
    m_fc = ({nr, ng, nb} != {m_r, m_g, m_b});
    m_fv = 1'b1;
    m_r = nr; m_g = ng; m_b = nb;
    m_count = (m_count + 1) % 65536;
    m_stale = 1'b0;
    partial.delete();
  endfunction

  function automatic void model_step(input bit strb, input bit en, input int s,
                                     input logic [7:0] dr, input logic [7:0] dg,
                                     input logic [7:0] db);
    rowd_t row;
    row.r = ~dr; row.g = ~dg; row.b = ~db;
    m_fv = 1'b0; m_fc = 1'b0; m_se = 1'b0;
    if (strb && en) begin
      idle = 0;
      if (hunting) begin
        if (s == 0) begin
          partial.delete();
          partial.push_back(row);
          hunting = 1'b0;
        end
      end else if (s == partial.size()) begin
        partial.push_back(row);
        if (partial.size() == ROWS) model_commit();
      end else begin
        m_se = 1'b1;
        partial.delete();
        if (s == 0) partial.push_back(row);
        else hunting = 1'b1;
      end
    end else begin
      if (idle >= T) begin
        m_stale = 1'b1;
        hunting = 1'b1;
        partial.delete();
      end
      idle++;
    end
  endfunction

  task automatic check_all();
    check("frame_valid",   64'(frame_valid),   64'(m_fv));
    check("frame_changed", 64'(frame_changed), 64'(m_fc));
    check("sync_err",      64'(sync_err),      64'(m_se));
    check("stale",         64'(stale),         64'(m_stale));
    check("frame_count",   64'(frame_count),   64'(m_count));
    check("frame_r",       frame_r,            m_r);
    check("frame_g",       frame_g,            m_g);
    check("frame_b",       frame_b,            m_b);
  endtask

  task automatic cyc(input bit strb, input bit en, input int s,
                     input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db);
    scan_strobe = strb;
    En          = en;
    S           = 3'(s);
    DATA_R = dr; DATA_G = dg; DATA_B = db;
    @(posedge clk);
    model_step(strb, en, s, dr, dg, db);
    #1;
    check_all();
  endtask

  task automatic row_ev(input int s, input logic [7:0] dr, input logic [7:0] dg,
                        input logic [7:0] db);
    cyc(1'b1, 1'b1, s, dr, dg, db);
  endtask

  function automatic logic [7:0] pat(input int seed, input int row, input int c);
    return 8'((seed * 53 + row * 29 + c * 7) ^ (seed << 3));
  endfunction

  logic [63:0] saved_r;
  int          mode, seed, gaps, s;

  initial begin
    restart = 1'b1;
    scan_strobe = 1'b0; En = 1'b0; S = '0;
    DATA_R = '0; DATA_G = '0; DATA_B = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    restart = 1'b0;

    // Single-pixel-pair frame, then an identical repeat.
    for (int r = 0; r < 8; r++) row_ev(r, ~8'h81, 8'hFF, 8'hFF);
    check("t1_frame_r", frame_r, {8{8'h81}});
    check("t1_frame_g", frame_g, 64'h0);
    check("t1_count",   64'(frame_count), 64'd1);
    check("t1_changed", 64'(frame_changed), 64'd1);
    check("t1_stale",   64'(stale), 64'd0);
    for (int r = 0; r < 8; r++) row_ev(r, ~8'h81, 8'hFF, 8'hFF);
    check("t2_valid",   64'(frame_valid), 64'd1);
    check("t2_changed", 64'(frame_changed), 64'd0);
    check("t2_count",   64'(frame_count), 64'd2);

    // Skipped row: error, then rows 5..7 are ignored while hunting.
    for (int r = 0; r < 3; r++) row_ev(r, 8'h00, 8'hFF, 8'hFF);
    row_ev(4, 8'h00, 8'hFF, 8'hFF);
    check("t3_sync_err", 64'(sync_err), 64'd1);
    for (int r = 5; r < 8; r++) row_ev(r, 8'h00, 8'hFF, 8'hFF);
    check("t3_no_frame", 64'(frame_count), 64'd2);
    for (int r = 0; r < 8; r++) row_ev(r, 8'h00, 8'hF0, 8'hFF);
    check("t3_count", 64'(frame_count), 64'd3);
    check("t3_frame_r", frame_r, {8{8'hFF}});

    // Early row 0 restarts the frame in place.
    for (int r = 0; r < 4; r++) row_ev(r, 8'h55, 8'hAA, 8'h0F);
    row_ev(0, 8'h33, 8'hAA, 8'h0F);
    check("t4_sync_err", 64'(sync_err), 64'd1);
    for (int r = 1; r < 8; r++) row_ev(r, 8'h33, 8'hAA, 8'h0F);
    check("t4_count", 64'(frame_count), 64'd4);
    check("t4_frame_r", frame_r, {8{8'hCC}});

    // Stall with disabled strobes still times out.
    saved_r = frame_r;
    for (int i = 0; i < T + 3; i++) cyc(i[0], 1'b0, i % 8, 8'h12, 8'h34, 8'h56);
    check("t5_stale", 64'(stale), 64'd1);
    check("t5_hold",  frame_r, saved_r);

    // Asynchronous restart mid-frame.
    for (int r = 0; r < 6; r++) row_ev(r, 8'h0F, 8'hF0, 8'h3C);
    #3 restart = 1'b1;
    #1;
    model_reset();
    check("t6_rst_count", 64'(frame_count), 64'd0);
    check("t6_rst_frame", frame_r, 64'h0);
    check("t6_rst_stale", 64'(stale), 64'd1);
    @(posedge clk);
    #1 restart = 1'b0;
    row_ev(6, 8'h0F, 8'hF0, 8'h3C);
    row_ev(7, 8'h0F, 8'hF0, 8'h3C);
    check("t6_no_valid", 64'(frame_valid), 64'd0);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      mode = int'($urandom_range(0, 9));
      if (mode <= 5) begin
        seed = int'($urandom_range(0, 3));
        for (int r = 0; r < 8; r++) begin
          gaps = int'($urandom_range(0, 2));
          for (int g = 0; g < gaps; g++)
            cyc($urandom_range(0, 1) == 1, 1'b0, int'($urandom_range(0, 7)),
                8'($urandom), 8'($urandom), 8'($urandom));
          s = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : r;
          row_ev(s, pat(seed, s, 0), pat(seed, s, 1), pat(seed, s, 2));
        end
      end else if (mode <= 7) begin
        for (int i = 0; i < 10; i++)
          cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        gaps = T - 2 + int'($urandom_range(0, 6));
        for (int i = 0; i < gaps; i++) cyc(1'b0, 1'b1, 0, 8'h00, 8'h00, 8'h00);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_frame_capture.md
# scan_frame_capture

Receive-side companion to the 8x8 LED row-scan driver. Samples the row-select/row-data bus the matrix sees (S, En, DATA_R/G/B), reassembles complete 8-row frames, and publishes each validated frame with a strobe. Detects out-of-order rows and a stalled scan. Sits beside the display driver for on-board self-check and bench scoreboarding of game output.

## Interface
Parameters:
- ROWS, 8, rows per frame; S width is $clog2(ROWS)
- COLS, 8, pixels per row
- ACTIVE_LOW, 1, 1 = a DATA bit of 0 lights the pixel
- TIMEOUT_CYC, 4096, clk cycles with no strobe before the scan is declared stale

Ports:
- clk  in  1  system clock; single clock domain
- restart  in  1  reset, asynchronous, active-high
- scan_strobe  in  1  one-cycle pulse: S/DATA_* are stable and valid this cycle
- En  in  1  matrix enable; rows sampled only while 1
- S  in  3  row select
- DATA_R, DATA_G, DATA_B  in  8 each  row data, polarity per ACTIVE_LOW
- frame_r, frame_g, frame_b  out  ROWS x COLS  last validated frame, 1 = lit
- frame_valid  out  1  one-cycle pulse when frame_* update
- frame_changed  out  1  with frame_valid: new frame differs from previous
- sync_err  out  1  one-cycle pulse on row-sequence violation
- stale  out  1  level: no complete frame since reset/timeout
- frame_count  out  16  validated frames, wraps 0xFFFF -> 0

## Operation
- Sample event = scan_strobe && En. Strobes with En=0 are ignored and do not reset the timeout.
- Sampled row normalised: lit = ACTIVE_LOW ? ~DATA : DATA; written into shadow row S.
- FSM:
  - HUNT: wait for event with S==0; store row 0, expect=1, go ASSEMBLE. Events with S!=0 are discarded, no sync_err.
  - ASSEMBLE: event with S==expect stores row; if expect==ROWS-1, commit and go HUNT-free: expect=0, stay ASSEMBLE (continuous scan). Event with S!=expect: sync_err pulse; if S==0 store row 0, expect=1, stay ASSEMBLE; else go HUNT.
- Commit: shadow (with final row merged same cycle) copied to frame_*; frame_valid=1; frame_changed = (new != previous frame_*); frame_count+1; stale cleared.
- Timeout: counter reset on every sample event, increments otherwise, saturates; reaching TIMEOUT_CYC sets stale=1 and FSM -> HUNT. frame_* hold last values.
- restart mid-frame: shadow discarded, all state to reset values.

## Timing
- Reset values: frame_* all 0, frame_valid 0, frame_changed 0, sync_err 0, stale 1, frame_count 0, FSM HUNT, expect 0, timeout counter 0.
- All outputs registered. frame_valid, frame_changed, frame_* update on the clk edge after the cycle containing the row-(ROWS-1) event: latency 1 cycle.
- sync_err asserted 1 cycle after the offending event, exactly one cycle wide.
- Back-to-back strobes every cycle supported; no minimum spacing.
- Timeout and event in the same cycle: event wins, counter cleared, stale unchanged.
- stale rises 1 cycle after counter reaches TIMEOUT_CYC.

## Structure
- Package scan_pkg: ROWS, COLS constants; typedef row_t (logic [COLS-1:0]); typedef frame_t (row_t [ROWS-1:0]); enum cap_state_t {HUNT, ASSEMBLE}.
- One sub-module: scan_row_norm (combinational polarity normalise of three colour rows). FSM, shadow, timeout and counters in the top.

## Test plan
- Reset, then 8 strobes S=0..7, DATA_R=~8'h81 each, G/B=8'hFF -> one frame_valid on cycle after S=7, frame_r every row 8'h81, g/b 0, frame_count=1, stale=0, frame_changed=1.
- Repeat identical frame -> frame_valid=1, frame_changed=0, frame_count=2.
- S=0,1,2,4 -> sync_err pulse on S=4 event, FSM HUNT; following S=5..7 ignored; next S=0..7 commits.
- S=0..3 then S=0 -> sync_err, row 0 restored, S=1..7 completes frame with no further error.
- No strobe for TIMEOUT_CYC cycles after a commit -> stale=1, frame_* unchanged; En=0 strobes do not prevent it.
- restart asserted asynchronously after S=0..5 -> outputs immediately at reset values; subsequent S=6,7 produce no frame_valid.
